// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and lane helpers for the data-memory responder
package dmem_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_WORD = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int LANE_W     = 8;

   function automatic logic [LANE_W-1:0] lane_select(input logic [31:0] word,
                                                      input logic [1:0]  lane);
      logic [LANE_W-1:0] b;
      b = word[7:0];
      case (lane)
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [WORD_BYTES-1:0] lane_be(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// rtl/dmem_ram_array.sv - single-port DEPTH x 32 RAM, synchronous read, per-byte write enables
module dmem_ram_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WORD_BYTES-1:0]    be_i,
   input  logic [31:0]              wdata_i,
   output logic [31:0]              rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
         if (be_i[b]) begin
            mem_q[addr_i][b*LANE_W +: LANE_W] <= wdata_i[b*LANE_W +: LANE_W];
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: valid/ready request/response around a byte-lane RAM
// Optional bounds check on addresses >= 4*DEPTH is enabled by DMEM_BOUNDS_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         AW     = $clog2(DEPTH);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic        byte_q, byte_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [AW-1:0]         ram_addr;
   logic [WORD_BYTES-1:0] ram_be;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;

   logic [1:0] lane;
   logic       misaligned;
   logic       out_of_range;
   logic       access_err;

   assign lane       = addr_q[1:0];
   assign misaligned = !byte_q && (lane != 2'b00);

`ifdef DMEM_BOUNDS_CHECK_EN
   assign out_of_range = (addr_q[31:AW+2] != '0);
`else
   logic unused_addr_hi;
   assign out_of_range   = 1'b0;
   assign unused_addr_hi = ^addr_q[31:AW+2];
`endif

   assign access_err = misaligned || out_of_range;

   // RAM read is synchronous: present the incoming address while idle so the
   // word is already on ram_rdata by the final ACCESS cycle, even when LATENCY=1.
   assign ram_addr  = (state_q == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
   assign ram_wdata = byte_q ? {WORD_BYTES{wdata_q[LANE_W-1:0]}} : wdata_q;

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      byte_d  = byte_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      ram_be  = '0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               byte_d  = (req_size == SIZE_BYTE);
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = LAT_M1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               err_d = access_err;
               if (access_err || we_q) begin
                  rdata_d = '0;
               end else if (byte_q) begin
                  rdata_d = {24'b0, lane_select(ram_rdata, lane)};
               end else begin
                  rdata_d = ram_rdata;
               end
               // A reset landing on the commit cycle drops the store.
               if (we_q && !access_err && !rst) begin
                  ram_be = byte_q ? lane_be(lane) : '1;
               end
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   dmem_ram_array #(
      .DEPTH(DEPTH)
   ) u_ram (
      .clk_i  (clk),
      .addr_i (ram_addr),
      .be_i   (ram_be),
      .wdata_i(ram_wdata),
      .rdata_o(ram_rdata)
   );

endmodule
